// File: rtl/uart_msg_arbiter_if.sv
// Bundle of the requester-side and WB2UART-side signals of uart_msg_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and models WB2UART.
interface uart_msg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]      in_req_valid;
  logic [34*N_REQ-1:0]   in_req_word;
  logic [N_REQ-1:0]      out_req_ready;
  logic [33:0]           out_WB2UART_word;
  logic                  out_WB2UART_cyc;
  logic                  in_WB2UART_stall;
  logic [ID_W-1:0]       out_grant_id;
  logic                  out_busy;
  logic                  out_timeout;

  modport slave (
    input  in_req_valid, in_req_word, in_WB2UART_stall,
    output out_req_ready, out_WB2UART_word, out_WB2UART_cyc,
           out_grant_id, out_busy, out_timeout
  );

  modport master (
    output in_req_valid, in_req_word, in_WB2UART_stall,
    input  out_req_ready, out_WB2UART_word, out_WB2UART_cyc,
           out_grant_id, out_busy, out_timeout
  );
endinterface

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter sharing one WB2UART hex-dump transmitter among N_REQ
// requesters. The winner's word is latched, a one-cycle cyc pulse starts
// WB2UART, and the stall flag is tracked until the transfer ends. A watchdog
// aborts the transaction if stall never rises after cyc.
// Optional: define UART_ARB_PRIO0_EN to give requester 0 fixed top priority;
// the remaining requesters then share round-robin among themselves.
module uart_msg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  uart_msg_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [7:0]       wdog_q, wdog_d;
  logic [33:0]      word_q, word_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic             cyc_q, cyc_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] cand;
  logic             win_found;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  grant_nxt;
  logic             rr_adv;

  // First set bit of c at or after ptr, wrapping modulo N_REQ; returns {found, idx}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] c,
                                            input logic [ID_W-1:0]  ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    int              pos;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!found && c[pos]) begin
        found = 1'b1;
        idx   = ID_W'(pos);
      end
    end
    return {found, idx};
  endfunction

  assign grant_nxt = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Winner selection for the next grant, and whether the finished grant moves rr_ptr.
  always_comb begin
    cand = bus.in_req_valid;
`ifdef UART_ARB_PRIO0_EN
    cand[0] = 1'b0;
    {win_found, win_idx} = rr_pick(cand, rr_ptr_q);
    if (bus.in_req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
    rr_adv = (grant_q != '0);
`else
    {win_found, win_idx} = rr_pick(cand, rr_ptr_q);
    rr_adv = 1'b1;
`endif
  end

  // Next-state and registered-output logic of the transaction FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    wdog_d    = wdog_q;
    word_d    = word_q;
    ready_d   = '0;
    cyc_d     = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d          = win_idx;
          word_d           = bus.in_req_word[34*win_idx +: 34];
          ready_d[win_idx] = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        cyc_d   = 1'b1;
        wdog_d  = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.in_WB2UART_stall) begin
          state_d = WAIT_DONE;
        end else if (wdog_q == 8'(ACK_TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          if (rr_adv) rr_ptr_d = grant_nxt;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.in_WB2UART_stall) begin
          state_d = IDLE;
          if (rr_adv) rr_ptr_d = grant_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears everything including the latched word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      wdog_q    <= '0;
      word_q    <= '0;
      ready_q   <= '0;
      cyc_q     <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      wdog_q    <= wdog_d;
      word_q    <= word_d;
      ready_q   <= ready_d;
      cyc_q     <= cyc_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.out_req_ready    = ready_q;
  assign bus.out_WB2UART_word = word_q;
  assign bus.out_WB2UART_cyc  = cyc_q;
  assign bus.out_grant_id     = grant_q;
  assign bus.out_busy         = busy_q;
  assign bus.out_timeout      = timeout_q;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Self-checking bench for uart_msg_arbiter. Expected grants are queued when
// requests are posted and compared when ready pulses appear. A WB2UART model
// raises stall two cycles after cyc and drops it stall_len cycles later, or
// never acknowledges when no_ack is set.
module tb_uart_msg_arbiter;
  localparam int N_REQ       = 4;
  localparam int ID_W        = 2;
  localparam int ACK_TIMEOUT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_msg_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  uart_msg_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [33:0]     word;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Requester k is valid while it has more posted than served requests.
  int posted[N_REQ];
  int served[N_REQ];
  always_comb begin
    bus.in_req_valid = '0;
    for (int k = 0; k < N_REQ; k++) bus.in_req_valid[k] = (posted[k] != served[k]);
  end

  int stall_len = 5;
  bit no_ack    = 1'b0;
  int n_timeouts = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] word_of(input int k, input int tag);
    return {2'(k), 16'(tag), 16'h5A00 + 16'(k)};
  endfunction

  task automatic set_word(input int k, input logic [33:0] w);
    bus.in_req_word[34*k +: 34] = w;
  endtask

  task automatic push(input int k, input logic [33:0] w);
    exp_t e;
    e.id   = ID_W'(k);
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int  cnt;
    bit  done;
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < budget) begin
      @(negedge clk);
      #1;
      cnt++;
      done = !bus.out_busy;
      for (int k = 0; k < N_REQ; k++) if (posted[k] != served[k]) done = 1'b0;
    end
    check("drain", done, 1'b1);
  endtask

  // WB2UART model and output monitor.
  initial begin
    int   cyc_n, t_ready, t_cyc, rise, hold, k_idx;
    bit   busy_chk, prev_cyc;
    logic [33:0] cur_word;
    exp_t e;
    bus.in_WB2UART_stall = 1'b0;
    cyc_n = 0; t_ready = 0; t_cyc = 0; rise = 0; hold = 0;
    busy_chk = 1'b0; prev_cyc = 1'b0; cur_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.in_WB2UART_stall = 1'b0;
        rise = 0; hold = 0; busy_chk = 1'b0; prev_cyc = 1'b0;
        continue;
      end
      cyc_n++;
      if (busy_chk) begin
        check("busy_drop", bus.out_busy, 1'b0);
        busy_chk = 1'b0;
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          check("busy_hold", bus.out_busy, 1'b1);
          check("word_hold", bus.out_WB2UART_word, cur_word);
          bus.in_WB2UART_stall = 1'b0;
          busy_chk = 1'b1;
        end
      end
      if (rise > 0) begin
        rise--;
        if (rise == 0) begin
          bus.in_WB2UART_stall = 1'b1;
          hold = stall_len;
        end
      end
      if (bus.out_req_ready != '0) begin
        check("ready_onehot", $countones(bus.out_req_ready), 1);
        k_idx = 0;
        for (int k = 0; k < N_REQ; k++) if (bus.out_req_ready[k]) k_idx = k;
        served[k_idx]++;
        t_ready  = cyc_n;
        cur_word = bus.out_WB2UART_word;
        if (sb.size() == 0) begin
          check("sb_underflow", k_idx, 99);
        end else begin
          e = sb.pop_front();
          check("ready_idx", k_idx, e.id);
          check("grant_id", bus.out_grant_id, e.id);
          check("grant_word", bus.out_WB2UART_word, e.word);
        end
      end
      if (bus.out_WB2UART_cyc) begin
        check("cyc_width", prev_cyc, 1'b0);
        check("cyc_latency", cyc_n - t_ready, 1);
        check("word_at_cyc", bus.out_WB2UART_word, cur_word);
        t_cyc = cyc_n;
        if (!no_ack) rise = 2;
      end
      prev_cyc = bus.out_WB2UART_cyc;
      if (bus.out_timeout) begin
        n_timeouts++;
        check("timeout_latency", cyc_n - t_cyc, ACK_TIMEOUT + 1);
        check("timeout_idle", bus.out_busy, 1'b0);
        check("timeout_expected", no_ack, 1'b1);
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int cnt;
    bus.in_req_word = '0;
    repeat (2) @(negedge clk);
    check("rst_state", {bus.out_req_ready, bus.out_WB2UART_word, bus.out_WB2UART_cyc,
                        bus.out_grant_id, bus.out_busy, bus.out_timeout}, '0);

`ifndef UART_ARB_PRIO0_EN
    // All four valid at reset exit; requester 0 asks twice.
    for (int k = 0; k < N_REQ; k++) set_word(k, word_of(k, 1));
    posted[0] += 2;
    for (int k = 1; k < N_REQ; k++) posted[k] += 1;
    push(0, word_of(0, 1)); push(1, word_of(1, 1)); push(2, word_of(2, 1));
    push(3, word_of(3, 1)); push(0, word_of(0, 1));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(1000);

    // Single request with a long WB2UART transfer.
    stall_len = 90;
    set_word(0, 34'h1_DEADBEEF);
    push(0, 34'h1_DEADBEEF);
    posted[0]++;
    wait_drain(1000);
    stall_len = 5;

`ifndef UART_ARB_PRIO0_EN
    // Fairness: requester 1 held, requester 3 asserted once after its first grant.
    set_word(1, word_of(1, 3));
    posted[1] += 4;
    push(1, word_of(1, 3));
    cnt = 0;
    while (served[1] == 0 + 3 && cnt < 0) cnt++;
    cnt = 0;
    while (sb.size() != 0 && cnt < 500) begin @(negedge clk); cnt++; end
    check("fair_first", sb.size(), 0);
    set_word(3, word_of(3, 3));
    posted[3]++;
    push(3, word_of(3, 3)); push(1, word_of(1, 3)); push(1, word_of(1, 3)); push(1, word_of(1, 3));
    wait_drain(1000);
`else
    // Requester 0 wins every arbitration while it is valid.
    set_word(0, word_of(0, 4));
    set_word(2, word_of(2, 4));
    posted[0] += 3;
    posted[2] += 1;
    push(0, word_of(0, 4)); push(0, word_of(0, 4)); push(0, word_of(0, 4)); push(2, word_of(2, 4));
    wait_drain(1000);
`endif

    // Watchdog: WB2UART never acknowledges requester 2's transfer.
    no_ack = 1'b1;
    set_word(2, word_of(2, 5));
    posted[2]++;
    push(2, word_of(2, 5));
    cnt = 0;
    while (n_timeouts == 0 && cnt < 500) begin @(negedge clk); cnt++; end
    check("timeout_seen", n_timeouts, 1);
    no_ack = 1'b0;
    wait_drain(200);
    // Round robin resumes after the aborted index.
    set_word(3, word_of(3, 5));
    posted[2]++;
    posted[3]++;
    push(3, word_of(3, 5)); push(2, word_of(2, 5));
    wait_drain(1000);

    // Reset in WAIT_DONE with requests 2 and 3 pending.
    set_word(3, word_of(3, 6));
    set_word(2, word_of(2, 6));
    posted[3]++;
    push(3, word_of(3, 6));
    cnt = 0;
    while (!bus.in_WB2UART_stall && cnt < 500) begin @(negedge clk); cnt++; end
    check("stall_seen", bus.in_WB2UART_stall, 1'b1);
    @(negedge clk);
    posted[2]++;
    posted[3]++;
    push(2, word_of(2, 6)); push(3, word_of(3, 6));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {bus.out_req_ready, bus.out_WB2UART_word, bus.out_WB2UART_cyc,
                        bus.out_grant_id, bus.out_busy, bus.out_timeout}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_drain(1000);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_msg_arbiter.md
Name: uart_msg_arbiter

Overview:
- Round-robin arbiter that shares one WB2UART hex-dump transmitter among N_REQ requesters.
- Each requester offers a 34-bit message word; the arbiter latches the winner, issues a single-cycle cyc pulse to WB2UART and tracks the stall (busy) flag until the 9-character transfer completes.
- A watchdog recovers if WB2UART never acknowledges. Sits between debug/trace sources and WB2UART → UartTx.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of grant index; must equal clog2(N_REQ), minimum 1
- ACK_TIMEOUT, 15, max cycles to wait for stall to rise after cyc before abort (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_req_valid  in  N_REQ  per-requester request; held high until matching ready pulse
- in_req_word  in  34*N_REQ  requester k word at bits [34k+33:34k]
- out_req_ready  out  N_REQ  one-cycle accept pulse to granted requester
- out_WB2UART_word  out  34  word to WB2UART, stable for whole transaction
- out_WB2UART_cyc  out  1  one-cycle start pulse to WB2UART
- in_WB2UART_stall  in  1  WB2UART busy flag
- out_grant_id  out  ID_W  index of requester currently or last served
- out_busy  out  1  high in any state other than IDLE
- out_timeout  out  1  one-cycle pulse when the watchdog aborts

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; rr_ptr=0; watchdog=0.
- All outputs registered.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If any in_req_valid, choose winner k = first valid index at or after rr_ptr, searching upward with wrap modulo N_REQ.
  - Latch word k into out_WB2UART_word and k into out_grant_id.
  - Pulse out_req_ready[k] in the same registered cycle; go to ISSUE.
- ISSUE: out_WB2UART_cyc=1 for exactly this cycle; clear watchdog; go to WAIT_ACK.
- WAIT_ACK:
  - If in_WB2UART_stall=1, go to WAIT_DONE.
  - Otherwise increment watchdog. When watchdog reaches ACK_TIMEOUT, pulse out_timeout, go to IDLE and advance rr_ptr.
- WAIT_DONE: when in_WB2UART_stall=0, go to IDLE and set rr_ptr = grant_id+1, wrapping to 0 after N_REQ-1.
- Latency: valid in IDLE → ready and word valid 1 cycle later → cyc 2 cycles later. Minimum 1 IDLE cycle between transactions.
- cyc is never high for two consecutive cycles; WB2UART restarts on every cyc-high cycle.
- Word bits pass through unmodified; bit32 selects the R/W prefix in WB2UART, bit33 is reserved.
- Requests arriving during non-IDLE states wait; they are not queued beyond the valid level.
- Simultaneous valids: only one ready pulse per grant, always the round-robin winner.
- Starvation bound: a held request is served within N_REQ grants.
- Valid dropped before ready: the request is withdrawn; no error.
- Stall already high in IDLE: arbiter still issues. Requester software must not share WB2UART with other masters.
- rst_n low mid-transaction: immediate return to IDLE, cyc and ready forced low, latched word cleared.

Optional Feature:
- Macro UART_ARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority. When in_req_valid[0] is high in IDLE it wins regardless of rr_ptr; the others use round-robin among themselves, and rr_ptr is updated only by grants to requesters 1..N_REQ-1.
- Undefined: pure round-robin as above.

Test Plan:
- Single request: req0 word=34'h1_DEADBEEF, stall rises 2 cycles after cyc and falls 90 cycles later → ready[0] pulse, cyc single pulse 1 cycle later, out_WB2UART_word=34'h1_DEADBEEF throughout, busy drops the cycle after stall falls.
- Simultaneous: all 4 valid at reset exit, each completing → grant order 0,1,2,3,0; exactly one ready per grant; no cyc pulse wider than 1 cycle.
- Fairness: req1 held continuously, req3 asserted once → req3 served within 2 grants of assertion.
- Timeout: stall held 0 after cyc → out_timeout pulses exactly ACK_TIMEOUT+1 cycles after cyc; FSM returns to IDLE; next grant goes to the next index.
- Reset mid WAIT_DONE: rst_n low for 3 cycles → all outputs 0 asynchronously; after release a pending req2 is granted first from rr_ptr=0 scan.
- With UART_ARB_PRIO0_EN: req0 and req2 valid repeatedly → req0 wins every arbitration while valid; req2 is served once req0 drops.
